rx_pre_align_buf: RTL and testbench

RX_PRE_ALIGN_BUF -- requirements
Module: rx_pre_align_buf

---
 rtl/rx_pre_align_buf.sv | 223 ++++++++++++++++++++++
 tb/tb_rx_pre_align_buf.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rx_pre_align_buf.sv
// rtl/rx_pre_align_buf.sv - receive pre-alignment buffer with SOF tagging, link FSM and statistics
// Statistics (ovf, OVF_CNT, RAW_FRAME_CNT) are built only when RX_PRE_BUF_STATS_EN is defined.
module rx_pre_align_buf #(
  parameter int DATA_WIDTH      = 256,
  parameter int DEPTH_LOG2      = 10,
  parameter int LINKUP_IDLE_CNT = 16,
  localparam int LANES          = DATA_WIDTH / 32,
  localparam int CW             = DATA_WIDTH / 8
) (
  input  logic                  x_clk,
  input  logic                  reset,
  input  logic                  x_we,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [CW-1:0]         ctrl_in,
  input  logic                  rd_en,
  input  logic                  rx_auto_clr_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CW-1:0]         ctrl_out,
  output logic                  out_valid,
  output logic [LANES-1:0]      br_sof,
  output logic [DEPTH_LOG2:0]   usedw,
  output logic                  full,
  output logic                  empty,
  output logic                  ovf,
  output logic [15:0]           OVF_CNT,
  output logic [31:0]           RAW_FRAME_CNT,
  output logic                  linkup
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int WW    = CW + DATA_WIDTH;
  localparam int CNT_W = $clog2(LINKUP_IDLE_CNT + 1);
  localparam logic [CNT_W-1:0] IDLE_TGT = CNT_W'(LINKUP_IDLE_CNT);

  // A lane carries SOF when its first byte is a control 0xFB.
  function automatic logic [LANES-1:0] sof_lanes(input logic [CW-1:0] c,
                                                 input logic [DATA_WIDTH-1:0] d);
    logic [LANES-1:0] s;
    for (int i = 0; i < LANES; i++) begin
      s[i] = c[4*i] && (d[32*i +: 8] == 8'hFB);
    end
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Circular buffer: pointers carry one extra MSB so full/empty are unambiguous
  // ---------------------------------------------------------------------------
  logic [WW-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                wr_acc;
  logic                rd_acc;
  logic [WW-1:0]       rd_word;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                  (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign usedw  = wr_ptr - rd_ptr;
  // A write is blocked at full even if a read frees a slot in the same cycle.
  assign wr_acc = x_we && !full;
  assign rd_acc = rd_en && !empty;
  assign rd_word = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // Storage array is deliberately left without reset.
  always_ff @(posedge x_clk) begin
    if (wr_acc) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= {ctrl_in, data_in};
    end
  end

  // Pointer advance; reset discards anything still buffered.
  always_ff @(posedge x_clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Registered read port: word, control and SOF lanes appear one cycle after the pull.
  always_ff @(posedge x_clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      ctrl_out  <= '0;
      br_sof    <= '0;
    end else begin
      out_valid <= rd_acc;
      if (rd_acc) begin
        data_out <= rd_word[DATA_WIDTH-1:0];
        ctrl_out <= rd_word[WW-1:DATA_WIDTH];
        br_sof   <= sof_lanes(rd_word[WW-1:DATA_WIDTH], rd_word[DATA_WIDTH-1:0]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Link state: classification looks at every offered beat, dropped or not
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_DOWN  = 2'd0,
    ST_CHECK = 2'd1,
    ST_UP    = 2'd2
  } link_state_t;

  link_state_t      state;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] idle_next;
  logic             beat_idle;
  logic             beat_err;

  assign idle_next = idle_cnt + 1'b1;

  // Beat classification: idle is all-control 0x07, error is any control 0xFE.
  always_comb begin
    beat_idle = &ctrl_in;
    beat_err  = 1'b0;
    for (int k = 0; k < CW; k++) begin
      if (data_in[8*k +: 8] != 8'h07) beat_idle = 1'b0;
      if (ctrl_in[k] && (data_in[8*k +: 8] == 8'hFE)) beat_err = 1'b1;
    end
  end

  // Link FSM with registered linkup; idle_cnt counts consecutive idles while checking.
  always_ff @(posedge x_clk or posedge reset) begin
    if (reset) begin
      state    <= ST_DOWN;
      idle_cnt <= '0;
      linkup   <= 1'b0;
    end else if (x_we) begin
      case (state)
        ST_DOWN: begin
          if (beat_idle) begin
            idle_cnt <= CNT_W'(1);
            if (LINKUP_IDLE_CNT <= 1) begin
              state  <= ST_UP;
              linkup <= 1'b1;
            end else begin
              state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (beat_err) begin
            state    <= ST_DOWN;
            idle_cnt <= '0;
          end else if (beat_idle) begin
            idle_cnt <= idle_next;
            if (idle_next == IDLE_TGT) begin
              state  <= ST_UP;
              linkup <= 1'b1;
            end
          end else begin
            idle_cnt <= '0;
          end
        end
        ST_UP: begin
          if (beat_err) begin
            state    <= ST_DOWN;
            idle_cnt <= '0;
            linkup   <= 1'b0;
          end
        end
        default: begin
          state    <= ST_DOWN;
          idle_cnt <= '0;
          linkup   <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef RX_PRE_BUF_STATS_EN
  logic        ovf_q;
  logic [15:0] ovf_cnt_q;
  logic [31:0] frame_cnt_q;
  logic        linkup_d;
  logic        wr_sof;
  logic        link_drop;

  assign wr_sof    = |sof_lanes(ctrl_in, data_in);
  // linkup only falls on UP->DOWN, so a falling edge marks the cycle after the drop.
  assign link_drop = linkup_d && !linkup;

  // Overflow flag/counter and SOF-beat counter; link-loss clear wins over increment.
  always_ff @(posedge x_clk or posedge reset) begin
    if (reset) begin
      ovf_q       <= 1'b0;
      ovf_cnt_q   <= '0;
      frame_cnt_q <= '0;
      linkup_d    <= 1'b0;
    end else begin
      linkup_d <= linkup;
      if (x_we && full) begin
        ovf_q <= 1'b1;
        if (ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
      end
      if (link_drop && rx_auto_clr_en) begin
        frame_cnt_q <= '0;
      end else if (wr_acc && wr_sof) begin
        frame_cnt_q <= frame_cnt_q + 32'd1;
      end
    end
  end

  assign ovf           = ovf_q;
  assign OVF_CNT       = ovf_cnt_q;
  assign RAW_FRAME_CNT = frame_cnt_q;
`else
  logic unused_stats;

  assign unused_stats  = rx_auto_clr_en;
  assign ovf           = 1'b0;
  assign OVF_CNT       = '0;
  assign RAW_FRAME_CNT = '0;
`endif

endmodule

// File: tb/tb_rx_pre_align_buf.sv
// tb/tb_rx_pre_align_buf.sv - directed self-checking bench for rx_pre_align_buf
// Statistics expectations follow RX_PRE_BUF_STATS_EN (zero when undefined).
module tb_rx_pre_align_buf;
  localparam int DW = 256;
  localparam int DL = 4;
  localparam int CW = DW / 8;
  localparam int LN = DW / 32;
`ifdef RX_PRE_BUF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [CW-1:0] IDLE_C = '1;
  localparam logic [DW-1:0] IDLE_D = {32{8'h07}};
  localparam logic [CW-1:0] ERR_C  = 32'h0000_0001;
  localparam logic [DW-1:0] ERR_D  = 256'hFE;
  localparam logic [CW-1:0] SOF_C  = 32'h0000_0001;
  localparam logic [DW-1:0] SOF_D  = 256'hFB;

  logic            x_clk = 1'b0;
  logic            reset;
  logic            x_we;
  logic [DW-1:0]   data_in;
  logic [CW-1:0]   ctrl_in;
  logic            rd_en;
  logic            rx_auto_clr_en;
  logic [DW-1:0]   data_out;
  logic [CW-1:0]   ctrl_out;
  logic            out_valid;
  logic [LN-1:0]   br_sof;
  logic [DL:0]     usedw;
  logic            full;
  logic            empty;
  logic            ovf;
  logic [15:0]     OVF_CNT;
  logic [31:0]     RAW_FRAME_CNT;
  logic            linkup;

  int checks = 0;
  int failures = 0;

  rx_pre_align_buf #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .LINKUP_IDLE_CNT(16)) dut (
    .x_clk(x_clk), .reset(reset), .x_we(x_we), .data_in(data_in), .ctrl_in(ctrl_in),
    .rd_en(rd_en), .rx_auto_clr_en(rx_auto_clr_en), .data_out(data_out), .ctrl_out(ctrl_out),
    .out_valid(out_valid), .br_sof(br_sof), .usedw(usedw), .full(full), .empty(empty),
    .ovf(ovf), .OVF_CNT(OVF_CNT), .RAW_FRAME_CNT(RAW_FRAME_CNT), .linkup(linkup)
  );

  always #5 x_clk = ~x_clk;

  function automatic logic [DW-1:0] pat(input int i);
    logic [31:0] w;
    w = 32'hA500_0000 + 32'(i);
    return {8{w}};
  endfunction

  task automatic beat(input logic we, input logic re, input logic [CW-1:0] c, input logic [DW-1:0] d);
    x_we = we; rd_en = re; ctrl_in = c; data_in = d;
    @(posedge x_clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; x_we = 1'b0; rd_en = 1'b0; rx_auto_clr_en = 1'b0;
    ctrl_in = '0; data_in = '0;
    #2;
    checks++; if (usedw !== 5'd0) begin failures++; $display("FAIL reset_usedw got=%0d exp=0", usedw); end
    checks++; if ({empty, full, out_valid, ovf, linkup} !== 5'b10000) begin failures++; $display("FAIL reset_flags got=%b exp=10000", {empty, full, out_valid, ovf, linkup}); end
    checks++; if (data_out !== '0 || ctrl_out !== '0 || br_sof !== '0) begin failures++; $display("FAIL reset_dout got=%h/%h/%h exp=0", data_out, ctrl_out, br_sof); end
    checks++; if (OVF_CNT !== 16'd0 || RAW_FRAME_CNT !== 32'd0) begin failures++; $display("FAIL reset_cnts got=%0d/%0d exp=0/0", OVF_CNT, RAW_FRAME_CNT); end
    @(posedge x_clk); #1;
    reset = 1'b0;
    beat(1'b0, 1'b1, '0, '0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) beat(1'b1, 1'b0, '0, pat(i));
    checks++; if (full !== 1'b1 || usedw !== 5'd16 || empty !== 1'b0) begin failures++; $display("FAIL fill_full got=full%b used%0d exp=full1 used16", full, usedw); end
    beat(1'b1, 1'b0, '0, pat(99));
    checks++; if (full !== 1'b1 || usedw !== 5'd16) begin failures++; $display("FAIL ovf_usedw got=%0d exp=16", usedw); end
    checks++; if (ovf !== STATS || OVF_CNT !== (STATS ? 16'd1 : 16'd0)) begin failures++; $display("FAIL ovf_cnt got=%b/%0d exp=%b/%0d", ovf, OVF_CNT, STATS, STATS ? 1 : 0); end
    for (int i = 0; i < 16; i++) begin
      beat(1'b0, 1'b1, '0, '0);
      checks++; if (out_valid !== 1'b1 || data_out !== pat(i) || ctrl_out !== '0) begin failures++; $display("FAIL drain_%0d got=v%b %h exp=v1 %h", i, out_valid, data_out[31:0], pat(i) & 32'hFFFF_FFFF); end
    end
    checks++; if (empty !== 1'b1 || usedw !== 5'd0) begin failures++; $display("FAIL drain_empty got=e%b used%0d exp=e1 used0", empty, usedw); end
    beat(1'b0, 1'b1, '0, '0);
    checks++; if (out_valid !== 1'b0 || data_out !== pat(15)) begin failures++; $display("FAIL rd_on_empty got=v%b %h exp=v0 hold", out_valid, data_out[31:0]); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, '0, pat(100 + i));
    checks++; if (usedw !== 5'd5) begin failures++; $display("FAIL sim_pre got=%0d exp=5", usedw); end
    beat(1'b1, 1'b1, '0, pat(105));
    checks++; if (usedw !== 5'd5 || out_valid !== 1'b1 || data_out !== pat(100)) begin failures++; $display("FAIL sim_rw5 got=used%0d v%b %h exp=used5 v1 a5000064", usedw, out_valid, data_out[31:0]); end
    for (int i = 106; i <= 116; i++) beat(1'b1, 1'b0, '0, pat(i));
    checks++; if (full !== 1'b1 || usedw !== 5'd16) begin failures++; $display("FAIL sim_full got=full%b used%0d exp=full1 used16", full, usedw); end
    beat(1'b1, 1'b1, '0, pat(200));
    checks++; if (usedw !== 5'd15 || full !== 1'b0 || data_out !== pat(101)) begin failures++; $display("FAIL sim_rw_full got=used%0d full%b %h exp=used15 full0 a5000065", usedw, full, data_out[31:0]); end
    checks++; if (OVF_CNT !== (STATS ? 16'd2 : 16'd0)) begin failures++; $display("FAIL sim_ovf_cnt got=%0d exp=%0d", OVF_CNT, STATS ? 2 : 0); end
    for (int i = 0; i < 15; i++) begin
      beat(1'b0, 1'b1, '0, '0);
      checks++; if (out_valid !== 1'b1 || data_out !== pat(102 + i)) begin failures++; $display("FAIL sim_drain_%0d got=v%b %h exp=v1 %h", i, out_valid, data_out[31:0], pat(102 + i) & 32'hFFFF_FFFF); end
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL sim_empty got=%b exp=1", empty); end
  endtask

  task automatic test_sof();
    beat(1'b1, 1'b0, 32'h0000_0010, 256'hFB << 32);
    checks++; if (RAW_FRAME_CNT !== (STATS ? 32'd1 : 32'd0)) begin failures++; $display("FAIL sof_cnt1 got=%0d exp=%0d", RAW_FRAME_CNT, STATS ? 1 : 0); end
    beat(1'b0, 1'b1, '0, '0);
    checks++; if (out_valid !== 1'b1 || br_sof !== 8'b0000_0010 || ctrl_out !== 32'h10) begin failures++; $display("FAIL sof_lane1 got=v%b sof%b ctrl%h exp=v1 sof00000010 ctrl10", out_valid, br_sof, ctrl_out); end
    beat(1'b1, 1'b0, 32'h0, 256'hFB << 32);
    beat(1'b0, 1'b1, '0, '0);
    checks++; if (out_valid !== 1'b1 || br_sof !== 8'h00) begin failures++; $display("FAIL sof_noctrl got=v%b sof%b exp=v1 sof00000000", out_valid, br_sof); end
    checks++; if (RAW_FRAME_CNT !== (STATS ? 32'd1 : 32'd0)) begin failures++; $display("FAIL sof_cnt_noctrl got=%0d exp=%0d", RAW_FRAME_CNT, STATS ? 1 : 0); end
    beat(1'b1, 1'b0, 32'h1000_0001, (256'hFB << 224) | 256'hFB);
    beat(1'b0, 1'b1, '0, '0);
    checks++; if (br_sof !== 8'h81 || RAW_FRAME_CNT !== (STATS ? 32'd2 : 32'd0)) begin failures++; $display("FAIL sof_lanes07 got=sof%b cnt%0d exp=sof10000001 cnt%0d", br_sof, RAW_FRAME_CNT, STATS ? 2 : 0); end
  endtask

  task automatic test_linkup();
    for (int i = 0; i < 16; i++) begin
      beat(1'b1, 1'b1, IDLE_C, IDLE_D);
      if (i == 14) begin
        checks++; if (linkup !== 1'b0) begin failures++; $display("FAIL link_idle15 got=%b exp=0", linkup); end
      end
    end
    checks++; if (linkup !== 1'b1) begin failures++; $display("FAIL link_idle16 got=%b exp=1", linkup); end
    beat(1'b1, 1'b1, ERR_C, ERR_D);
    checks++; if (linkup !== 1'b0) begin failures++; $display("FAIL link_err got=%b exp=0", linkup); end
    for (int i = 0; i < 15; i++) beat(1'b1, 1'b1, IDLE_C, IDLE_D);
    beat(1'b1, 1'b1, '0, pat(7));
    for (int i = 0; i < 15; i++) beat(1'b1, 1'b1, IDLE_C, IDLE_D);
    checks++; if (linkup !== 1'b0) begin failures++; $display("FAIL link_broken_run got=%b exp=0", linkup); end
    checks++; if (RAW_FRAME_CNT !== (STATS ? 32'd2 : 32'd0)) begin failures++; $display("FAIL link_cnt_kept got=%0d exp=%0d", RAW_FRAME_CNT, STATS ? 2 : 0); end
  endtask

  task automatic test_auto_clr();
    beat(1'b1, 1'b1, ERR_C, ERR_D);
    for (int i = 0; i < 16; i++) beat(1'b1, 1'b1, IDLE_C, IDLE_D);
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b1, SOF_C, SOF_D);
    checks++; if (linkup !== 1'b1 || RAW_FRAME_CNT !== (STATS ? 32'd7 : 32'd0)) begin failures++; $display("FAIL clr_pre got=l%b cnt%0d exp=l1 cnt%0d", linkup, RAW_FRAME_CNT, STATS ? 7 : 0); end
    rx_auto_clr_en = 1'b1;
    beat(1'b1, 1'b1, ERR_C, ERR_D);
    checks++; if (linkup !== 1'b0 || RAW_FRAME_CNT !== (STATS ? 32'd7 : 32'd0)) begin failures++; $display("FAIL clr_drop got=l%b cnt%0d exp=l0 cnt%0d", linkup, RAW_FRAME_CNT, STATS ? 7 : 0); end
    beat(1'b0, 1'b1, '0, '0);
    checks++; if (RAW_FRAME_CNT !== 32'd0) begin failures++; $display("FAIL clr_next got=%0d exp=0", RAW_FRAME_CNT); end
    rx_auto_clr_en = 1'b0;
    for (int i = 0; i < 16; i++) beat(1'b1, 1'b1, IDLE_C, IDLE_D);
    for (int i = 0; i < 7; i++) beat(1'b1, 1'b1, SOF_C, SOF_D);
    beat(1'b1, 1'b1, ERR_C, ERR_D);
    beat(1'b0, 1'b1, '0, '0);
    checks++; if (linkup !== 1'b0 || RAW_FRAME_CNT !== (STATS ? 32'd7 : 32'd0)) begin failures++; $display("FAIL noclr_keep got=l%b cnt%0d exp=l0 cnt%0d", linkup, RAW_FRAME_CNT, STATS ? 7 : 0); end
  endtask

  task automatic test_reset_mid();
    beat(1'b0, 1'b1, '0, '0);
    beat(1'b0, 1'b1, '0, '0);
    for (int i = 0; i < 16; i++) beat(1'b1, 1'b1, IDLE_C, IDLE_D);
    for (int i = 0; i < 8; i++) beat(1'b1, 1'b0, '0, pat(300 + i));
    beat(1'b1, 1'b1, '0, pat(308));
    checks++; if (usedw !== 5'd9 || linkup !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre got=used%0d l%b v%b exp=used9 l1 v1", usedw, linkup, out_valid); end
    #2 reset = 1'b1;
    #1;
    checks++; if (usedw !== 5'd0 || {empty, full, out_valid, linkup, ovf} !== 5'b10000) begin failures++; $display("FAIL mid_async got=used%0d flags%b exp=used0 flags10000", usedw, {empty, full, out_valid, linkup, ovf}); end
    checks++; if (data_out !== '0 || ctrl_out !== '0 || br_sof !== '0 || OVF_CNT !== 16'd0 || RAW_FRAME_CNT !== 32'd0) begin failures++; $display("FAIL mid_async_data got=%h/%h/%h/%0d/%0d exp=0", data_out[31:0], ctrl_out, br_sof, OVF_CNT, RAW_FRAME_CNT); end
    x_we = 1'b0; rd_en = 1'b0;
    @(posedge x_clk); #1;
    reset = 1'b0;
    beat(1'b1, 1'b0, '0, pat(400));
    checks++; if (usedw !== 5'd1) begin failures++; $display("FAIL mid_restart_used got=%0d exp=1", usedw); end
    beat(1'b0, 1'b1, '0, '0);
    checks++; if (out_valid !== 1'b1 || data_out !== pat(400) || empty !== 1'b1) begin failures++; $display("FAIL mid_restart_data got=v%b %h e%b exp=v1 a5000190 e1", out_valid, data_out[31:0], empty); end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_simultaneous();
    test_sof();
    test_linkup();
    test_auto_clr();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
